// File: rtl/ysyx_csr_file.sv
// Machine-mode CSR file for the RV64 core. It implements mstatus, mtvec,
// mepc and mcause, with combinational Zicsr reads and ECALL trap side effects.
// The optional mscratch (0x340) is built only when CSR_MSCRATCH_EN is defined.
module ysyx_csr_file #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            Csrwen,
  input  logic [2:0]      CsrOp,
  input  logic [11:0]     CsrId,
  input  logic [XLEN-1:0] datain,
  input  logic            Ecall,
  input  logic [XLEN-1:0] epc_in,
  output logic [XLEN-1:0] csrres,
  output logic [XLEN-1:0] mtvec_o,
  output logic [XLEN-1:0] mepc_o
);

  localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;

  localparam logic [XLEN-1:0] MSTATUS_RST = XLEN'(64'h0000_000A_0000_1800);
  localparam logic [XLEN-1:0] CAUSE_ECALL = XLEN'(11);

  typedef enum logic [1:0] {
    FN_NONE = 2'b00,
    FN_RW   = 2'b01,
    FN_RS   = 2'b10,
    FN_RC   = 2'b11
  } csr_fn_e;

  logic [XLEN-1:0] r_mstatus;
  logic [XLEN-1:0] r_mtvec;
  logic [XLEN-1:0] r_mepc;
  logic [XLEN-1:0] r_mcause;
`ifdef CSR_MSCRATCH_EN
  logic [XLEN-1:0] r_mscratch;
`endif

  csr_fn_e         w_fn;
  logic            w_wr;
  logic [XLEN-1:0] w_old;
  logic [XLEN-1:0] w_new;
  logic [XLEN-1:0] w_mstatus_trap;

  // The register and immediate forms share a function. Bit 2 only selects
  // where the operand came from, and the caller has already resolved that.
  assign w_fn = csr_fn_e'(CsrOp[1:0]);
  assign w_wr = Csrwen && (w_fn != FN_NONE);

  // Read the old value of the addressed CSR. Unimplemented ids read as zero.
  always_comb begin
    w_old = '0;
    unique case (CsrId)
      ADDR_MSTATUS:  w_old = r_mstatus;
      ADDR_MTVEC:    w_old = r_mtvec;
      ADDR_MEPC:     w_old = r_mepc;
      ADDR_MCAUSE:   w_old = r_mcause;
`ifdef CSR_MSCRATCH_EN
      ADDR_MSCRATCH: w_old = r_mscratch;
`endif
      default:       w_old = '0;
    endcase
  end

  // Compute the read/modify/write result from the old value and the operand.
  always_comb begin
    w_new = w_old;
    unique case (w_fn)
      FN_RW:   w_new = datain;
      FN_RS:   w_new = w_old | datain;
      FN_RC:   w_new = w_old & ~datain;
      default: w_new = w_old;
    endcase
  end

  // Trap entry on mstatus: MPIE takes MIE, MIE is cleared and MPP is set to M.
  always_comb begin
    w_mstatus_trap        = r_mstatus;
    w_mstatus_trap[7]     = r_mstatus[3];
    w_mstatus_trap[3]     = 1'b0;
    w_mstatus_trap[12:11] = 2'b11;
  end

  // mstatus: an ECALL overrides a CSR write on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                r_mstatus <= MSTATUS_RST;
    else if (Ecall)                          r_mstatus <= w_mstatus_trap;
    else if (w_wr && CsrId == ADDR_MSTATUS)  r_mstatus <= w_new;
  end

  // mtvec: updated only by CSR writes, including during an ECALL.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                r_mtvec <= '0;
    else if (w_wr && CsrId == ADDR_MTVEC)    r_mtvec <= w_new;
  end

  // mepc: an ECALL captures the PC of the trapping instruction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                r_mepc <= '0;
    else if (Ecall)                          r_mepc <= epc_in;
    else if (w_wr && CsrId == ADDR_MEPC)     r_mepc <= w_new;
  end

  // mcause: an ECALL records the environment call from M-mode.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                r_mcause <= '0;
    else if (Ecall)                          r_mcause <= CAUSE_ECALL;
    else if (w_wr && CsrId == ADDR_MCAUSE)   r_mcause <= w_new;
  end

`ifdef CSR_MSCRATCH_EN
  // mscratch: a plain scratch register that an ECALL does not change.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                r_mscratch <= '0;
    else if (w_wr && CsrId == ADDR_MSCRATCH) r_mscratch <= w_new;
  end
`endif

  assign csrres  = w_old;
  assign mtvec_o = r_mtvec;
  assign mepc_o  = r_mepc;

endmodule

// File: tb/tb_ysyx_csr_file.sv
// Directed, table-driven bench for ysyx_csr_file. It covers reset, the
// RW/RS/RC ops and their immediate forms, ECALL and its priority over CSR
// writes, unimplemented and gated writes, optional mscratch, and async reset.
module tb_ysyx_csr_file;

  logic        clk;
  logic        rst;
  logic        Csrwen;
  logic [2:0]  CsrOp;
  logic [11:0] CsrId;
  logic [63:0] datain;
  logic        Ecall;
  logic [63:0] epc_in;
  logic [63:0] csrres;
  logic [63:0] mtvec_o;
  logic [63:0] mepc_o;

  int unsigned n_checks;
  int unsigned n_fails;

  typedef struct {
    logic        wen;
    logic [2:0]  op;
    logic [11:0] id;
    logic [63:0] din;
    logic        ecall;
    logic [63:0] epc;
    logic [63:0] exp_res;
    logic [63:0] exp_mtvec;
    logic [63:0] exp_mepc;
  } vec_t;

  vec_t vecs[$];

  ysyx_csr_file #(.XLEN(64)) dut (
    .clk     (clk),
    .rst     (rst),
    .Csrwen  (Csrwen),
    .CsrOp   (CsrOp),
    .CsrId   (CsrId),
    .datain  (datain),
    .Ecall   (Ecall),
    .epc_in  (epc_in),
    .csrres  (csrres),
    .mtvec_o (mtvec_o),
    .mepc_o  (mepc_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic wen, input logic [2:0] op, input logic [11:0] id,
                     input logic [63:0] din, input logic ecall, input logic [63:0] epc,
                     input logic [63:0] er, input logic [63:0] et, input logic [63:0] ep);
    vec_t v;
    v.wen = wen; v.op = op; v.id = id; v.din = din; v.ecall = ecall; v.epc = epc;
    v.exp_res = er; v.exp_mtvec = et; v.exp_mepc = ep;
    vecs.push_back(v);
  endtask

  task automatic idle();
    Csrwen = 1'b0; CsrOp = 3'b000; CsrId = 12'h000; datain = '0;
    Ecall = 1'b0; epc_in = '0;
  endtask

  logic [63:0] exp_scratch;

  initial begin
    n_checks = 0;
    n_fails  = 0;
`ifdef CSR_MSCRATCH_EN
    exp_scratch = 64'h1234;
`else
    exp_scratch = 64'h0;
`endif

    // Each row gives the inputs, then the expected csrres, mtvec_o and mepc_o
    // before the edge. Writes appear in the following row.
    //   wen  op      id      din                    ecall epc                 res                    mtvec           mepc
    add(0, 3'b000, 12'h300, 64'h0,                 0, 64'h0,             64'h0000_000A_0000_1800, 64'h0,          64'h0);
    add(1, 3'b001, 12'h305, 64'h8000_0100,         0, 64'h0,             64'h0,                   64'h0,          64'h0);
    add(1, 3'b010, 12'h305, 64'h3,                 0, 64'h0,             64'h8000_0100,           64'h8000_0100,  64'h0);
    add(0, 3'b000, 12'h305, 64'h0,                 0, 64'h0,             64'h8000_0103,           64'h8000_0103,  64'h0);
    add(1, 3'b011, 12'h300, 64'h1800,              0, 64'h0,             64'h0000_000A_0000_1800, 64'h8000_0103,  64'h0);
    add(1, 3'b110, 12'h300, 64'h8,                 0, 64'h0,             64'h0000_000A_0000_0000, 64'h8000_0103,  64'h0);
    add(0, 3'b000, 12'h300, 64'h0,                 0, 64'h0,             64'h0000_000A_0000_0008, 64'h8000_0103,  64'h0);
    add(0, 3'b000, 12'h342, 64'h0,                 1, 64'h8000_0040,     64'h0,                   64'h8000_0103,  64'h0);
    add(0, 3'b000, 12'h300, 64'h0,                 0, 64'h0,             64'h0000_000A_0000_1880, 64'h8000_0103,  64'h8000_0040);
    add(0, 3'b000, 12'h342, 64'h0,                 0, 64'h0,             64'd11,                  64'h8000_0103,  64'h8000_0040);
    add(1, 3'b001, 12'h341, 64'h5,                 1, 64'h8000_0080,     64'h8000_0040,           64'h8000_0103,  64'h8000_0040);
    add(0, 3'b000, 12'h341, 64'h0,                 0, 64'h0,             64'h8000_0080,           64'h8000_0103,  64'h8000_0080);
    add(1, 3'b001, 12'h305, 64'h200,               1, 64'h8000_00C0,     64'h8000_0103,           64'h8000_0103,  64'h8000_0080);
    add(0, 3'b000, 12'h305, 64'h0,                 0, 64'h0,             64'h200,                 64'h200,        64'h8000_00C0);
    add(0, 3'b000, 12'h300, 64'h0,                 0, 64'h0,             64'h0000_000A_0000_1800, 64'h200,        64'h8000_00C0);
    add(1, 3'b001, 12'h7C0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 64'h0,           64'h0,                   64'h200,        64'h8000_00C0);
    add(0, 3'b000, 12'h7C0, 64'h0,                 0, 64'h0,             64'h0,                   64'h200,        64'h8000_00C0);
    add(0, 3'b001, 12'h305, 64'hFFFF,              0, 64'h0,             64'h200,                 64'h200,        64'h8000_00C0);
    add(1, 3'b100, 12'h305, 64'h5,                 0, 64'h0,             64'h200,                 64'h200,        64'h8000_00C0);
    add(0, 3'b000, 12'h305, 64'h0,                 0, 64'h0,             64'h200,                 64'h200,        64'h8000_00C0);
    add(1, 3'b101, 12'h342, 64'h7,                 0, 64'h0,             64'd11,                  64'h200,        64'h8000_00C0);
    add(1, 3'b111, 12'h342, 64'h3,                 0, 64'h0,             64'h7,                   64'h200,        64'h8000_00C0);
    add(0, 3'b000, 12'h342, 64'h0,                 0, 64'h0,             64'h4,                   64'h200,        64'h8000_00C0);
    add(1, 3'b001, 12'h340, 64'h1234,              0, 64'h0,             64'h0,                   64'h200,        64'h8000_00C0);
    add(1, 3'b001, 12'h341, 64'h8000_0103,         0, 64'h0,             64'h8000_00C0,           64'h200,        64'h8000_00C0);
    add(0, 3'b000, 12'h340, 64'h0,                 0, 64'h0,             exp_scratch,             64'h200,        64'h8000_0103);

    // Initial reset, asserted between edges with no clock edge.
    idle();
    rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    CsrId = 12'h300;
    #1;
    check("reset_mstatus", csrres, 64'h0000_000A_0000_1800);
    check("reset_mtvec",   mtvec_o, 64'h0);
    check("reset_mepc",    mepc_o,  64'h0);
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      Csrwen = vecs[i].wen;  CsrOp = vecs[i].op;  CsrId = vecs[i].id;
      datain = vecs[i].din;  Ecall = vecs[i].ecall; epc_in = vecs[i].epc;
      #1;
      check($sformatf("vec%0d_csrres", i), csrres,  vecs[i].exp_res);
      check($sformatf("vec%0d_mtvec",  i), mtvec_o, vecs[i].exp_mtvec);
      check($sformatf("vec%0d_mepc",   i), mepc_o,  vecs[i].exp_mepc);
    end

    // Async reset mid-operation. A write is held active while reset asserts
    // between edges, and reset must win through the following edge.
    @(negedge clk);
    idle();
    Csrwen = 1'b1; CsrOp = 3'b001; CsrId = 12'h305; datain = 64'hDEAD;
    #2 rst = 1'b0;
    #1;
    check("async_mtvec", mtvec_o, 64'h0);
    check("async_mepc",  mepc_o,  64'h0);
    check("async_csrres_mtvec", csrres, 64'h0);
    Csrwen = 1'b0; CsrOp = 3'b000;
    CsrId = 12'h300; #1;
    check("async_mstatus", csrres, 64'h0000_000A_0000_1800);
    CsrId = 12'h342; #1;
    check("async_mcause", csrres, 64'h0);
    CsrId = 12'h340; #1;
    check("async_mscratch", csrres, 64'h0);
    Csrwen = 1'b1; CsrOp = 3'b001; CsrId = 12'h305; Ecall = 1'b1; epc_in = 64'h44;
    @(posedge clk); #1;
    check("reset_hold_mtvec", mtvec_o, 64'h0);
    check("reset_hold_mepc",  mepc_o,  64'h0);
    @(negedge clk);
    idle();
    rst = 1'b1;

    // Write after the reset is released, to confirm the file runs again.
    @(negedge clk);
    Csrwen = 1'b1; CsrOp = 3'b001; CsrId = 12'h305; datain = 64'h55;
    @(negedge clk);
    idle();
    #1;
    check("post_reset_mtvec", mtvec_o, 64'h55);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
